// File: rtl/alu_cmd_sequencer.sv
// Command front end for the 16-bit ALU: buffers commands in a small FIFO, issues
// them one at a time to the registered-result ALU and returns tagged results.
//
// state   | meaning
// IDLE    | nothing in flight; pops the FIFO head when one is present
// ISSUE   | alu_* registers hold the command; ALU samples them at the end of this cycle
// CAPTURE | alu_result is valid; it is registered into rsp_result at the end of this cycle
// RESPOND | rsp_valid is high and held stable until the consumer takes it
module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [3:0]                       cmd_opcode,
  input  logic [15:0]                      cmd_a,
  input  logic [15:0]                      cmd_b,
  input  logic [TAG_W-1:0]                 cmd_tag,
  output logic [3:0]                       alu_opcode,
  output logic [15:0]                      alu_operandA,
  output logic [15:0]                      alu_operandB,
  input  logic [31:0]                      alu_result,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [31:0]                      rsp_result,
  output logic [TAG_W-1:0]                 rsp_tag,
  output logic                             rsp_illegal,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  cmd_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [3:0] LAST_LEGAL_OP = 4'b1010;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESPOND} state_t;

  state_t           state;
  logic [3:0]       q_op  [FIFO_DEPTH];
  logic [15:0]      q_a   [FIFO_DEPTH];
  logic [15:0]      q_b   [FIFO_DEPTH];
  logic [TAG_W-1:0] q_tag [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TAG_W-1:0] tag_q;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [3:0]       head_op;
  logic [15:0]      head_a;
  logic [15:0]      head_b;
  logic [TAG_W-1:0] head_tag;
  logic             head_illegal;

  assign full         = (cmd_count == CNT_W'(FIFO_DEPTH));
  assign empty        = (cmd_count == '0);
  assign cmd_ready    = !full && !reset;
  assign push         = cmd_valid && cmd_ready;
  // RESPOND always has rsp_valid set, so rsp_ready alone completes the handshake
  assign pop          = !empty && ((state == IDLE) || ((state == RESPOND) && rsp_ready));
  assign head_op      = q_op[rd_ptr];
  assign head_a       = q_a[rd_ptr];
  assign head_b       = q_b[rd_ptr];
  assign head_tag     = q_tag[rd_ptr];
  assign head_illegal = (head_op > LAST_LEGAL_OP);
  assign busy         = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]  <= cmd_opcode;
      q_a[wr_ptr]   <= cmd_a;
      q_b[wr_ptr]   <= cmd_b;
      q_tag[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cmd_count    <= '0;
      tag_q        <= '0;
      alu_opcode   <= '0;
      alu_operandA <= '0;
      alu_operandB <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_tag      <= '0;
      rsp_illegal  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cmd_count <= cmd_count + CNT_W'(1);
        2'b01:   cmd_count <= cmd_count - CNT_W'(1);
        default: cmd_count <= cmd_count;
      endcase

      if (pop) begin
        // illegal opcodes never reach the ALU; they answer directly with a zero result
        if (head_illegal) begin
          rsp_result  <= '0;
          rsp_illegal <= 1'b1;
          rsp_tag     <= head_tag;
          rsp_valid   <= 1'b1;
          state       <= RESPOND;
        end else begin
          alu_opcode   <= head_op;
          alu_operandA <= head_a;
          alu_operandB <= head_b;
          tag_q        <= head_tag;
          rsp_valid    <= 1'b0;
          state        <= ISSUE;
        end
      end else begin
        case (state)
          ISSUE: state <= CAPTURE;
          CAPTURE: begin
            rsp_result  <= alu_result;
            rsp_tag     <= tag_q;
            rsp_illegal <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESPOND;
          end
          RESPOND: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: an ALU model, a response scoreboard kept in push
// order, directed latency/backpressure/reset scenarios and randomized traffic.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [15:0]   cmd_a;
  logic [15:0]   cmd_b;
  logic [TW-1:0] cmd_tag;
  logic [3:0]    alu_opcode;
  logic [15:0]   alu_operandA;
  logic [15:0]   alu_operandB;
  logic [31:0]   alu_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_result;
  logic [TW-1:0] rsp_tag;
  logic          rsp_illegal;
  logic          busy;
  logic [$clog2(DEPTH+1)-1:0] cmd_count;

  logic ready_ctl;
  logic rand_mode;
  logic rnd_ready = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0]   res;
    logic [TW-1:0] tag;
    logic          ill;
  } exp_t;
  exp_t exp_q[$];

  logic          hold;
  logic [31:0]   h_res;
  logic [TW-1:0] h_tag;
  logic          h_ill;

  always #5 clk = ~clk;

  assign rsp_ready = rand_mode ? rnd_ready : ready_ctl;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
    .busy(busy), .cmd_count(cmd_count)
  );

  // ALU: ADD SUB MUL DIV AND OR XOR NOT SHL INC DEC, signed operands, 32-bit result
  function automatic logic [31:0] alu_f(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    case (op)
      4'd0:    return 32'(ia + ib);
      4'd1:    return 32'(ia - ib);
      4'd2:    return 32'(ia * ib);
      4'd3:    return (ib == 0) ? 32'd0 : 32'(ia / ib);
      4'd4:    return {16'd0, a & b};
      4'd5:    return {16'd0, a | b};
      4'd6:    return {16'd0, a ^ b};
      4'd7:    return {16'd0, ~a};
      4'd8:    return 32'(ia <<< 1);
      4'd9:    return 32'(ia + 1);
      4'd10:   return 32'(ia - 1);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) alu_result <= alu_f(alu_opcode, alu_operandA, alu_operandB);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every cycle, outstanding work implies busy, responses come in push order
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold = 1'b0;
    end else begin
      chk("busy_vs_outstanding", busy, exp_q.size() != 0);
      if (exp_q.size() == 0) chk("no_stale_rsp", rsp_valid, 0);
      if (hold) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_result", rsp_result, h_res);
        chk("hold_tag", rsp_tag, h_tag);
        chk("hold_illegal", rsp_illegal, h_ill);
      end
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.ill = (cmd_opcode > 4'd10);
        e.res = e.ill ? 32'd0 : alu_f(cmd_opcode, cmd_a, cmd_b);
        e.tag = cmd_tag;
        exp_q.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_tag", rsp_tag, e.tag);
          chk("rsp_illegal", rsp_illegal, e.ill);
        end
      end
      hold  = rsp_valid && !rsp_ready;
      h_res = rsp_result;
      h_tag = rsp_tag;
      h_ill = rsp_illegal;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [TW-1:0] tag);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_tag    = tag;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        step();
        cmd_valid = 1'b0;
        return;
      end
      step();
    end
    chk("push_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] res, input logic [TW-1:0] tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk({name, "_result"}, rsp_result, res);
        chk({name, "_tag"}, rsp_tag, tag);
        chk({name, "_illegal"}, rsp_illegal, 0);
        step();
        return;
      end
      step();
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk("drain_empty", exp_q.size(), 0);
    step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    ready_ctl = 1'b0; rand_mode = 1'b0;
    step(); step();
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_count", cmd_count, 0);
    chk("reset_busy", busy, 0);
    chk("reset_alu_opcode", alu_opcode, 0);
    chk("reset_rsp_result", rsp_result, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);
    step();

    // ADD 5 + 7, exact latency
    ready_ctl = 1'b1;
    push(4'd0, 16'd5, 16'd7, 4'd3);
    @(negedge clk); chk("add_lat0", rsp_valid, 0);
    step(); @(negedge clk); chk("add_lat1", rsp_valid, 0);
    step(); @(negedge clk); chk("add_lat2", rsp_valid, 0);
    step(); @(negedge clk);
    chk("add_valid", rsp_valid, 1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_tag", rsp_tag, 4'd3);
    chk("add_illegal", rsp_illegal, 0);
    step(); @(negedge clk);
    chk("add_busy_after", busy, 0);
    chk("add_valid_after", rsp_valid, 0);
    step();

    // MUL then DIV, in order
    push(4'd2, 16'hFED4, 16'd200, 4'd1);
    push(4'd3, 16'd100, 16'd7, 4'd2);
    wait_rsp("mul", 32'hFFFF15A0, 4'd1);
    wait_rsp("div", 32'd14, 4'd2);
    drain();

    // illegal opcode answers after one edge and leaves the ALU registers alone
    push(4'hF, 16'h1234, 16'h5678, 4'd9);
    @(negedge clk); chk("ill_lat0", rsp_valid, 0);
    step(); @(negedge clk);
    chk("ill_valid", rsp_valid, 1);
    chk("ill_result", rsp_result, 0);
    chk("ill_flag", rsp_illegal, 1);
    chk("ill_tag", rsp_tag, 4'd9);
    chk("ill_alu_opcode", alu_opcode, 4'd3);
    chk("ill_alu_a", alu_operandA, 16'd100);
    chk("ill_alu_b", alu_operandB, 16'd7);
    step();
    drain();

    // backpressure: fill the FIFO behind a held response
    ready_ctl = 1'b0;
    for (int i = 1; i <= 5; i++)
      push(4'($urandom_range(0, 10)), 16'($urandom), 16'($urandom), TW'(i));
    cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 16'd1000; cmd_b = 16'hFFFF; cmd_tag = 4'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("full_count", cmd_count, 4);
      chk("full_ready", cmd_ready, 0);
      chk("full_valid", rsp_valid, 1);
      chk("full_tag", rsp_tag, 4'd1);
      step();
    end
    ready_ctl = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = 1'b1;
        step();
        break;
      end
      step();
    end
    cmd_valid = 1'b0;
    chk("sixth_accepted", acc, 1);
    drain();

    // simultaneous push and pop at occupancy 2
    ready_ctl = 1'b0;
    push(4'd1, 16'd50, 16'd8, 4'd10);
    push(4'd2, 16'd3, 16'd4, 4'd11);
    push(4'd9, 16'd77, 16'd0, 4'd12);
    step(); @(negedge clk); chk("pp_before", cmd_count, 2);
    step();
    cmd_valid = 1'b1; cmd_opcode = 4'd6; cmd_a = 16'h00FF; cmd_b = 16'h0F0F; cmd_tag = 4'd13;
    ready_ctl = 1'b1;
    @(negedge clk); chk("pp_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    @(negedge clk); chk("pp_after", cmd_count, 2);
    step();
    drain();

    // pointer wrap with incrementing tags, then random traffic, random rsp_ready
    rand_mode = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++)
      push(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), TW'(i + 1));
    drain();
    for (int i = 0; i < 40; i++) begin
      push(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), TW'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end
    drain();
    rand_mode = 1'b0;

    // reset while in CAPTURE with 3 commands queued
    ready_ctl = 1'b0;
    for (int i = 1; i <= 5; i++) push(4'd2, 16'd300, TW'(i) + 16'd1, TW'(i));
    ready_ctl = 1'b1;
    step();
    ready_ctl = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_pre_count", cmd_count, 3);
    chk("rst_pre_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_count", cmd_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_a", alu_operandA, 0);
    chk("rst_alu_b", alu_operandB, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    step();
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side front end for the 16-bit ALU. It accepts ALU commands (opcode, two signed operands, tag) over a valid/ready handshake and buffers them in a small FIFO. It issues one command at a time to the ALU's registered-result interface, captures the 32-bit result, and returns it with its tag over a second valid/ready handshake. In the design it sits between the instruction/cache side and the ALU.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, >= 2
TAG_W, 4, width of the command/response tag

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_opcode  in  4  ALU opcode (0000 ADD ... 1010 DEC)
cmd_a  in  16  signed operand A
cmd_b  in  16  signed operand B
cmd_tag  in  TAG_W  caller tag, returned with the result
alu_opcode  out  4  drives the ALU opcode input (registered)
alu_operandA  out  16  drives ALU operandA (registered)
alu_operandB  out  16  drives ALU operandB (registered)
alu_result  in  32  ALU registered result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_result  out  32  signed result
rsp_tag  out  TAG_W  tag of the completed command
rsp_illegal  out  1  opcode was > 4'b1010; result forced to 0
busy  out  1  FSM not in IDLE or FIFO non-empty
cmd_count  out  clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (synchronous, on the clk edge with reset=1):
  - FIFO flushed, cmd_count=0.
  - FSM goes to IDLE.
  - alu_opcode=0, alu_operandA=0, alu_operandB=0.
  - rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_illegal=0, busy=0.
  - Any in-flight command and any pending response are discarded.
  - cmd_ready=0 while reset=1.
- FIFO:
  - cmd_ready = !full.
  - A push occurs on cmd_valid & cmd_ready.
  - Push and pop may happen in the same cycle; occupancy is then unchanged.
  - When full, cmd_ready stays 0 even if a pop occurs in that cycle.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - Order is strictly FIFO.
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND.
  - IDLE: if the FIFO is non-empty, pop the head.
    - Legal opcode: load alu_* registers and the internal tag register; go to ISSUE.
    - Illegal opcode (1011..1111): do not touch the alu_* registers; load rsp_result=0, rsp_illegal=1, rsp_tag; set rsp_valid=1; go to RESPOND.
  - ISSUE: one cycle. The ALU samples alu_* on the edge ending this cycle. Go to CAPTURE.
  - CAPTURE: alu_result is valid during this cycle. On the edge, rsp_result<=alu_result, rsp_tag<=tag, rsp_illegal<=0, rsp_valid<=1; go to RESPOND.
  - RESPOND: hold all rsp_* stable while rsp_valid & !rsp_ready.
    - On rsp_ready with FIFO non-empty: pop the next command and go directly to ISSUE (or stay in RESPOND for an illegal opcode). rsp_valid stays 1 only in the illegal case; otherwise it drops to 0.
    - On rsp_ready with FIFO empty: rsp_valid<=0; go to IDLE.
- Latency:
  - Legal command accepted at edge N into an empty, idle sequencer: rsp_valid=1 after edge N+3.
  - Illegal command under the same conditions: rsp_valid=1 after edge N+1.
  - Sustained throughput with rsp_ready=1: one legal response per 3 cycles.
- Width rules:
  - alu_result is passed through unmodified; the ALU defines sign/zero extension per opcode.
  - No saturation or overflow flags.
- The alu_* registers keep the last issued values when not in ISSUE, so the ALU recomputes the same op harmlessly.
- busy = (state != IDLE) | (cmd_count != 0).

Test Plan:
- ADD, 5 + 7, tag 3, pushed at edge 0 with rsp_ready=1 -> rsp_valid high after edge 3; rsp_result=12, rsp_tag=3, rsp_illegal=0; busy=0 after the handshake.
- MUL, -300 × 200 -> rsp_result=32'hFFFF15A0 (-60000); DIV 100 / 7 -> rsp_result=14. Responses arrive in push order with tags 1 and 2.
- rsp_ready=0, six back-to-back pushes:
  - First command issued, then held in RESPOND.
  - Next four fill the FIFO: cmd_count=4, cmd_ready=0, sixth stalls.
  - rsp stays stable for 10 cycles.
  - Raising rsp_ready then drains all six in order.
- Opcode 4'b1111, tag 9 -> rsp_valid after 1 edge with rsp_result=0, rsp_illegal=1, rsp_tag=9; alu_opcode unchanged from its previous value.
- Simultaneous push and pop at cmd_count=2 -> cmd_count stays 2. Pointer wrap-around is checked over 3×FIFO_DEPTH commands with incrementing tags.
- Reset asserted for 1 cycle while in CAPTURE with 3 entries queued -> next cycle rsp_valid=0, cmd_count=0, busy=0, alu_* = 0. No stale response after reset deasserts.
